mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares one single-port, variable-latency memory between instruction fetch and the data-memory stage.
- Data-stage access flags (read/write/byte) come from the decoder.
- Data has priority over fetch; a starvation counter guarantees fetch progress.
- One transaction is outstanding at a time. Requesters see a one-cycle ready pulse, which stalls the pipeline until it arrives.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, word width (must be 32).
- STARVE_LIMIT, 2, consecutive data grants allowed while fetch is pending (1..15).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; level, held until if_ready.
- if_addr  in  ADDR_WIDTH  fetch address; must be word-aligned.
- if_rdata  out  32  fetched word; valid while if_ready=1.
- if_ready  out  1  one-cycle completion pulse for fetch.
- d_read  in  1  data read (decoder mem_read); held until d_ready.
- d_write  in  1  data write (decoder mem_write); held until d_ready.
- d_byte  in  1  byte access (decoder mem_byte).
- d_addr  in  ADDR_WIDTH  data byte address.
- d_wdata  in  32  store data; bits [7:0] are used when d_byte=1.
- d_rdata  out  32  load data; zero-extended for byte loads; valid while d_ready=1.
- d_ready  out  1  one-cycle completion pulse for data.
- mem_req  out  1  memory request; level, held until mem_ready.
- mem_we  out  1  write enable.
- mem_byte  out  1  byte access.
- mem_addr  out  ADDR_WIDTH  address to memory.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data; byte reads are returned in [7:0].
- mem_ready  in  1  one-cycle completion pulse from memory (at least 1 cycle after mem_req rises).
- misalign_err  out  1  sticky flag: word data access with d_addr[1:0] != 0.
- proto_err  out  1  sticky flag: d_read and d_write both high at grant.

Behaviour:
- Reset (asynchronous, immediate):
  - All outputs go to 0 and the state goes to IDLE.
  - grant_id=0 and starve_cnt=0.
  - An in-flight memory transaction is abandoned (mem_req drops at once).
  - Any mem_ready arriving after reset release with no transaction open is ignored.
- States: IDLE, BUSY, RESP. The register grant_id (0=fetch, 1=data) records the current owner.
- IDLE:
  - Let d_pend = d_read|d_write.
  - If d_pend && if_req: grant fetch if starve_cnt==STARVE_LIMIT, otherwise grant data.
  - If only one request is present, grant it. If none, stay in IDLE.
- On grant:
  - Register mem_addr, mem_we (=d_write for data, 0 for fetch), mem_byte (=d_byte for data, 0 for fetch) and mem_wdata.
  - Assert mem_req from the next cycle; move to BUSY.
- Misaligned data word access (d_byte=0, d_addr[1:0]!=0):
  - No memory transaction is issued; set misalign_err.
  - Go directly to RESP with d_rdata=0.
- d_read&d_write at grant: set proto_err and treat the access as a write.
- Starvation counter:
  - On a data grant with if_req=1: starve_cnt++ (saturating at STARVE_LIMIT).
  - On a fetch grant, or a data grant with if_req=0: starve_cnt=0.
- BUSY:
  - mem_* outputs are held stable; mem_req=1.
  - On mem_ready: capture mem_rdata (data byte read keeps [7:0], zero-extended), deassert mem_req, move to RESP.
  - Without mem_ready: stay in BUSY (no timeout).
- RESP:
  - Exactly one cycle. Pulse if_ready or d_ready according to grant_id, with the matching rdata valid.
  - The other ready stays 0; next state is IDLE.
  - No grant is made in RESP, so a request still held in this cycle is not re-served.
- Requester rule: drop or change the request in the cycle after its ready pulse.
- Latency: request sampled in IDLE at cycle t; mem_req=1 at t+1; mem_ready at t+k; ready pulse at t+k+1; IDLE at t+k+2.
- Latency is 3 cycles minimum (k=1). Back-to-back issue interval is k+2.
- mem_ready outside BUSY: ignored.
- if_rdata and d_rdata: hold their last value outside ready cycles (not guaranteed by the interface).
- Sticky error flags: cleared only by reset.

Test Plan:
- Fetch only, if_addr=0x100, memory k=2 returns 0xDEADBEEF -> mem_req high for cycles 1-2, mem_we=0, if_ready pulse in cycle 3 with if_rdata=0xDEADBEEF, d_ready stays 0.
- Byte load, d_read=1, d_byte=1, d_addr=0x203, mem_rdata=0x123456A5 -> mem_byte=1, mem_addr=0x203, d_rdata=0x000000A5 on the d_ready pulse.
- Word store, d_write=1, d_addr=0x40, d_wdata=0xCAFEF00D -> mem_we=1, mem_wdata=0xCAFEF00D, single d_ready pulse, misalign_err=0.
- Fetch and data held continuously with STARVE_LIMIT=2 -> grant order D, D, I, D, D, I; each requester sees exactly one ready per completed transaction.
- Word load with d_addr=0x42 -> no mem_req; d_ready pulses 1 cycle after the grant with d_rdata=0; misalign_err=1 until reset.
- rst_n low during BUSY (k=5, cycle 2) -> mem_req drops immediately, no ready pulse. After release, a stray mem_ready is ignored and the next fetch is served normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-port, variable-latency memory between instruction fetch
//   and the data-memory stage. Data normally wins; a starvation counter forces
//   a fetch grant after STARVE_LIMIT consecutive data grants while fetch waits.
//   Only one transaction is open at a time, and each requester gets a single
//   cycle ready pulse when its access completes.
//
// Ports
//   clk, rst_n                clock, asynchronous active-low reset
//   if_req/if_addr            fetch request (level) and word-aligned address
//   if_rdata/if_ready         fetched word, one-cycle completion pulse
//   d_read/d_write/d_byte     data access flags from the decoder (level)
//   d_addr/d_wdata            data byte address and store data
//   d_rdata/d_ready           load data (byte loads zero-extended), pulse
//   mem_req/mem_we/mem_byte   memory request (level until mem_ready) + flags
//   mem_addr/mem_wdata        memory address and write data
//   mem_rdata/mem_ready       memory read data and one-cycle completion pulse
//   misalign_err              sticky: word data access with d_addr[1:0] != 0
//   proto_err                 sticky: d_read and d_write both high at grant
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_ready,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic                  d_byte,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ready,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  mem_byte,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  misalign_err,
  output logic                  proto_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state_q, state_d;
  logic       grant_id;     // owner of the open transaction: 0 fetch, 1 data
  logic [3:0] starve_cnt;

  logic d_pend;
  logic grant_any;
  logic grant_data;
  logic misalign;

  // Arbitration and next state. Only evaluated as a grant while in IDLE.
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    d_pend     = d_read | d_write;
    grant_any  = 1'b0;
    grant_data = 1'b0;
    misalign   = 1'b0;
    state_d    = state_q;
    case (state_q)
      IDLE: begin
        grant_any  = d_pend | if_req;
        // Fetch only wins a collision once data has used up its quota.
        grant_data = d_pend && !(if_req && (starve_cnt == LIMIT));
        misalign   = grant_data && !d_byte && (d_addr[1:0] != 2'b00);
        if (grant_any) state_d = misalign ? RESP : BUSY;
      end
      BUSY:    if (mem_ready) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Request/response datapath.
  // NOTE: every register here, including the wide data registers, has an
  // asynchronous reset so the outputs are all zero the moment reset asserts
  // and an in-flight request is dropped immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_id     <= 1'b0;
      starve_cnt   <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_byte     <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      if_rdata     <= '0;
      d_rdata      <= '0;
      misalign_err <= 1'b0;
      proto_err    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            grant_id <= grant_data;
            if (grant_data) begin
              // A read+write collision is treated as a write.
              mem_we     <= d_write;
              mem_byte   <= d_byte;
              mem_addr   <= d_addr;
              mem_wdata  <= d_wdata;
              starve_cnt <= !if_req ? 4'd0 :
                            (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 4'd1;
              if (d_read && d_write) proto_err <= 1'b1;
              if (misalign) begin
                // Short-circuit straight to the response; memory never sees it.
                misalign_err <= 1'b1;
                d_rdata      <= '0;
              end else begin
                mem_req <= 1'b1;
              end
            end else begin
              mem_we     <= 1'b0;
              mem_byte   <= 1'b0;
              mem_addr   <= if_addr;
              mem_wdata  <= '0;
              starve_cnt <= '0;
              mem_req    <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            if (grant_id) begin
              d_rdata <= mem_byte ? {{(DATA_WIDTH-8){1'b0}}, mem_rdata[7:0]}
                                  : mem_rdata;
            end else begin
              if_rdata <= mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Ready pulses are decoded from the one-cycle RESP state.
  assign if_ready = (state_q == RESP) && !grant_id;
  assign d_ready  = (state_q == RESP) &&  grant_id;

endmodule
